muldiv_seq: RTL

- Multi-cycle sequencer for the ALU's MUL/DIV operations; replaces the single-cycle combinational multiply/divide path.
- Iterative shift-add multiplier and restoring divider share one 64-bit working register and a 5-bit iteration counter.
- Sits beside the execute-stage ALU and raises busy so the pipeline stalls until the product or quotient/remainder pair is accepted.

---
 rtl/muldiv_seq_if.sv | 43 ++++
 rtl/muldiv_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if
// Handshake and data bundle between the execute stage and the multi-cycle
// MUL/DIV sequencer.
//
// Signals:
//   start      - request a new operation (sampled only when accepting)
//   op_div     - 0 = multiply, 1 = divide
//   signed_op  - signed operands (honoured only with MULDIV_SIGNED_EN)
//   x, y       - multiplicand/dividend and multiplier/divisor
//   abort      - pipeline flush, cancels any operation in progress
//   result_ack - consumer accepts lo/hi while done is high
//   busy       - sequencer occupied (BUSY or DONE)
//   done       - result valid, held until acknowledged
//   lo, hi     - low product word / quotient, high product word / remainder
//
// Modports: master = pipeline side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             signed_op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             abort;
    logic             result_ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, op_div, signed_op, x, y, abort, result_ack,
        input  busy, done, lo, hi
    );

    modport slave (
        input  start, op_div, signed_op, x, y, abort, result_ack,
        output busy, done, lo, hi
    );
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Multi-cycle MUL/DIV sequencer for the execute-stage ALU. A shift-add
// multiplier and a restoring divider share one 2*WIDTH working register and
// an iteration counter; one bit is processed per cycle, giving a fixed
// latency from accept to done for every operand value.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - muldiv_seq_if.slave (start/op_div/signed_op/x/y/abort/
//            result_ack in, busy/done/lo/hi out)
//
// Configuration:
//   MULDIV_SIGNED_EN - when defined, signed_op=1 runs the iteration on
//   operand magnitudes and sign-corrects the result on completion. When
//   undefined, signed_op is ignored and all operations are unsigned.
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               isDiv_q, isDiv_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;

    logic               acceptOp;
    logic [WIDTH-1:0]   xMag;
    logic [WIDTH-1:0]   yMag;

    // Multiply step: accumulator is {partial product, remaining multiplier}.
    // The add is one bit wider so the carry lands in the top bit after the
    // right shift.
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;

    // Divide step: accumulator is {remainder, remaining dividend/quotient}.
    logic [WIDTH:0]     divRem;
    logic [WIDTH+1:0]   divDiff;
    logic [2*WIDTH-1:0] divNext;

    logic [2*WIDTH-1:0] stepNext;
    logic [WIDTH-1:0]   resLo;
    logic [WIDTH-1:0]   resHi;

    assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mulNext = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

    // Trial subtraction on the shifted remainder; a borrow out of the extra
    // top bit means the divisor did not fit, so the shifted value is kept.
    assign divRem  = acc_q[2*WIDTH-1:WIDTH-1];
    assign divDiff = {1'b0, divRem} - {2'b00, opnd_q};
    assign divNext = divDiff[WIDTH+1]
                   ? {divRem[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0}
                   : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign stepNext = isDiv_q ? divNext : mulNext;

    // A new operation is taken from IDLE, or from DONE when the result is
    // acknowledged in the same cycle. Abort always wins.
    assign acceptOp = bus.start && !bus.abort &&
                      ((state_q == IDLE) || ((state_q == DONE) && bus.result_ack));

`ifdef MULDIV_SIGNED_EN
    logic xs_q, xs_d;
    logic ys_q, ys_d;
    logic xNeg, yNeg;
    logic [2*WIDTH-1:0] mulSigned;
    logic [WIDTH-1:0]   quotSigned;
    logic [WIDTH-1:0]   remSigned;

    assign xNeg = bus.signed_op && bus.x[WIDTH-1];
    assign yNeg = bus.signed_op && bus.y[WIDTH-1];
    assign xMag = xNeg ? -bus.x : bus.x;
    assign yMag = yNeg ? -bus.y : bus.y;

    // Sign correction of the final iteration's output. A zero divisor forces
    // an all-ones quotient; the remainder then equals the original dividend
    // because the magnitude is re-negated when the dividend was negative.
    always_comb begin
        mulSigned  = (xs_q ^ ys_q) ? -stepNext : stepNext;
        quotSigned = stepNext[WIDTH-1:0];
        if (opnd_q == '0) begin
            quotSigned = '1;
        end else if (xs_q ^ ys_q) begin
            quotSigned = -stepNext[WIDTH-1:0];
        end
        remSigned = xs_q ? -stepNext[2*WIDTH-1:WIDTH] : stepNext[2*WIDTH-1:WIDTH];
        if (isDiv_q) begin
            resLo = quotSigned;
            resHi = remSigned;
        end else begin
            resLo = mulSigned[WIDTH-1:0];
            resHi = mulSigned[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_q <= 1'b0;
            ys_q <= 1'b0;
        end else begin
            xs_q <= xs_d;
            ys_q <= ys_d;
        end
    end

    always_comb begin
        xs_d = xs_q;
        ys_d = ys_q;
        if (acceptOp) begin
            xs_d = xNeg;
            ys_d = yNeg;
        end
    end
`else
    assign xMag  = bus.x;
    assign yMag  = bus.y;
    assign resLo = stepNext[WIDTH-1:0];
    assign resHi = stepNext[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            isDiv_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            isDiv_q <= isDiv_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // lo/hi are written only on the BUSY->DONE transition so they hold the
    // last completed result through IDLE and across aborts.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        isDiv_d = isDiv_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                BUSY: begin
                    acc_d = stepNext;
                    if (count_q == LAST) begin
                        state_d = DONE;
                        lo_d    = resLo;
                        hi_d    = resHi;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.result_ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Multiply keeps the multiplier in the low half and the multiplicand
        // aside; divide keeps the dividend in the low half and the divisor
        // aside.
        if (acceptOp) begin
            state_d = BUSY;
            count_d = '0;
            isDiv_d = bus.op_div;
            opnd_d  = bus.op_div ? yMag : xMag;
            acc_d   = {{WIDTH{1'b0}}, (bus.op_div ? xMag : yMag)};
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;

endmodule
